rtc_calendar_core: RTL and testbench
====================================

Name: rtc_calendar_core

Overview:
- Parametrised free-running real-time clock and calendar core: seconds/minutes/hours with full carry into day/month/year, month-length and leap-year aware.
- Generalises the earlier set-only time controller. Adds a tick prescaler, a true carry chain, 12/24-hour display mode and per-field UP/DOWN editing with wrap and day clamping.
- Sits between the button/blink controller, which drives FIELD_SEL/UP/DOWN, and the digit separator/decoder stage.

Parameters:
- TICK_DIV, 100: CLK cycles per second. Legal values are 2 or more.
- CNT_W, 7: prescaler width. Must satisfy 2^CNT_W >= TICK_DIV.
- YEAR_MAX, 99: last year value. Year wraps YEAR_MAX -> 0.

Ports:
- CLK input 1: system clock, rising edge.
- RESET input 1: asynchronous, active-high reset.
- EN input 1: enables timekeeping. When 0, the prescaler holds and no ticks occur.
- SET_HOLD input 1: freezes seconds counting while the user edits. The prescaler is held at 0.
- TIME_FORMAT input 1: 0 = 24h display, 1 = 12h display.
- FIELD_SEL input 3: field select. 1 = HOUR, 2 = MIN, 3 = SEC, 4 = MERIDIAN, 5 = YEAR, 6 = MONTH, 7 = DAY, 0 = none.
- UP input 1: single-cycle increment request for the selected field.
- DOWN input 1: single-cycle decrement request for the selected field.
- HOUR output 5: internal hour, always 0..23.
- HOUR_DISP output 5: 0..23 in 24h mode; 1..12 in 12h mode.
- PM output 1: 1 when HOUR >= 12.
- MIN output 6: 0..59.
- SEC output 6: 0..59.
- YEAR output 7: 0..YEAR_MAX.
- MONTH output 4: 1..12.
- DAY output 5: 1..days_in_month.
- SEC_TICK output 1: one-cycle pulse in the cycle SEC advances through the carry chain.
- DAY_ROLL output 1: one-cycle pulse in the cycle DAY advances through the carry chain.

Behaviour:
- Reset values, applied asynchronously on RESET:
  - prescaler = 0
  - HOUR/MIN/SEC = 0; PM = 0; HOUR_DISP = 0 in 24h mode or 12 in 12h mode (combinational)
  - YEAR = 0, MONTH = 1, DAY = 1
  - SEC_TICK = 0, DAY_ROLL = 0
  - A reset mid-edit or mid-carry discards everything in progress.
- Prescaler:
  - When EN=1 and SET_HOLD=0, it counts 0..TICK_DIV-1.
  - At TICK_DIV-1 it returns to 0 and fires an internal tick.
  - When SET_HOLD=1, it is forced to 0.
- Carry chain on tick, all fields updated in the same clock edge (registered, visible 1 cycle after the tick cycle):
  - SEC 59 -> 0 carries into MIN.
  - MIN 59 -> 0 carries into HOUR.
  - HOUR 23 -> 0 carries into DAY.
  - DAY at days_in_month -> 1 carries into MONTH.
  - MONTH 12 -> 1 carries into YEAR.
  - YEAR YEAR_MAX -> 0, with no further carry.
  - SEC_TICK is registered with the SEC update. DAY_ROLL is registered with the DAY update.
- days_in_month:
  - 31 for months 1, 3, 5, 7, 8, 10, 12.
  - 30 for months 4, 6, 9, 11.
  - Month 2: 29 if YEAR[1:0] == 0, else 28.
- Edit (UP xor DOWN, FIELD_SEL != 0):
  - The selected field changes by +/-1, wrapping within its own range: HOUR 0..23, MIN/SEC 0..59, YEAR 0..YEAR_MAX, MONTH 1..12, DAY 1..days_in_month.
  - An edit never carries into a neighbouring field.
  - MERIDIAN edit, UP or DOWN: HOUR becomes HOUR+12 if HOUR < 12, otherwise HOUR-12.
  - SEC edit also clears the prescaler.
- Clamping: after a MONTH or YEAR change (edit or carry), if DAY > new days_in_month, DAY = days_in_month in the same edge. Example: 31 Mar, DOWN on MONTH gives 28 Feb (or 29 Feb in a leap year).
- Simultaneous events:
  - UP and DOWN both high: no edit.
  - UP or DOWN with FIELD_SEL = 0: no edit.
  - Edit and tick in the same cycle: the edit is applied, the tick is discarded and SEC_TICK stays 0.
- Display:
  - HOUR_DISP in 12h mode: 0 -> 12, 1..12 unchanged, 13..23 -> HOUR-12.
  - PM is combinational from HOUR.
  - TIME_FORMAT changes affect only HOUR_DISP; they never modify stored state.

Test Plan:
- Reset check: assert RESET with a clock running, release it, sample outputs. Expect 00:00:00, YEAR 0, MONTH 1, DAY 1, PM 0, HOUR_DISP 0. Set TIME_FORMAT = 1 and expect HOUR_DISP 12.
- Prescaler: TICK_DIV = 4, EN = 1. Expect a SEC_TICK pulse every 4th cycle and SEC 0 -> 1 -> 2. With SET_HOLD = 1 for 10 cycles, expect no SEC_TICK and SEC unchanged.
- Full rollover: preset 99-12-31 23:59:59 and apply one tick. Expect 00-01-01 00:00:00 with SEC_TICK and DAY_ROLL each high for exactly one cycle.
- Leap year and clamping:
  - YEAR 4, 02-28 23:59:59, tick: expect 02-29.
  - YEAR 5, same start: expect 03-01.
  - 03-31, DOWN on MONTH with YEAR 5: expect 02-28.
- Edit wrap and priority:
  - MIN 0 with DOWN: expect MIN 59 and HOUR unchanged.
  - HOUR 23 with UP: expect HOUR 0 and DAY unchanged.
  - UP and DOWN together: expect no change.
  - Edit coincident with a tick: expect only the edit applied and SEC_TICK = 0.
- 12h/meridian: HOUR 13 with TIME_FORMAT = 1 gives HOUR_DISP 1 and PM 1. A MERIDIAN UP edit then gives HOUR 1 and PM 0. HOUR 0 with a MERIDIAN DOWN edit gives HOUR 12.

Source files
------------

// File: rtl/rtc_calendar_core.sv
// Free-running RTC/calendar: prescaled seconds tick, full carry chain into Y/M/D,
// leap-year aware day clamping, per-field UP/DOWN editing and 12/24h display.
module rtc_calendar_core #(
  parameter int TICK_DIV = 100,
  parameter int CNT_W    = 7,
  parameter int YEAR_MAX = 99
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       EN,
  input  logic       SET_HOLD,
  input  logic       TIME_FORMAT,
  input  logic [2:0] FIELD_SEL,
  input  logic       UP,
  input  logic       DOWN,
  output logic [4:0] HOUR,
  output logic [4:0] HOUR_DISP,
  output logic       PM,
  output logic [5:0] MIN,
  output logic [5:0] SEC,
  output logic [6:0] YEAR,
  output logic [3:0] MONTH,
  output logic [4:0] DAY,
  output logic       SEC_TICK,
  output logic       DAY_ROLL
);

  localparam logic [CNT_W-1:0] PRESC_MAX = CNT_W'(TICK_DIV - 1);
  localparam logic [6:0]       YMAX      = 7'(YEAR_MAX);

  localparam logic [2:0] F_HOUR = 3'd1, F_MIN = 3'd2, F_SEC = 3'd3, F_MER = 3'd4,
                         F_YEAR = 3'd5, F_MONTH = 3'd6, F_DAY = 3'd7;

  logic [CNT_W-1:0] presc_q, presc_d;
  logic [4:0] hour_q, hour_d, day_q, day_d;
  logic [5:0] min_q, min_d, sec_q, sec_d;
  logic [6:0] year_q, year_d;
  logic [3:0] month_q, month_d;
  logic       sec_tick_q, sec_tick_d, day_roll_q, day_roll_d;
  logic       edit, tick;
  logic [4:0] dim_cur, dim_new;

  function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic [6:0] y);
    case (m)
      4'd2:                    return (y[1:0] == 2'b00) ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
      default:                 return 5'd31;
    endcase
  endfunction

  assign edit    = (UP ^ DOWN) && (FIELD_SEL != 3'd0);
  assign tick    = EN && !SET_HOLD && (presc_q == PRESC_MAX);
  assign dim_cur = days_in_month(month_q, year_q);

  always_comb begin
    presc_d    = presc_q;
    hour_d     = hour_q;
    min_d      = min_q;
    sec_d      = sec_q;
    year_d     = year_q;
    month_d    = month_q;
    day_d      = day_q;
    sec_tick_d = 1'b0;
    day_roll_d = 1'b0;
    dim_new    = 5'd31;

    if (SET_HOLD || (edit && FIELD_SEL == F_SEC)) begin
      presc_d = '0;
    end else if (EN) begin
      presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
    end

    // An edit always wins over a coincident tick; the tick is simply lost.
    if (edit) begin
      case (FIELD_SEL)
        F_HOUR:  hour_d  = UP ? ((hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1)
                              : ((hour_q == 5'd0) ? 5'd23 : hour_q - 5'd1);
        F_MIN:   min_d   = UP ? ((min_q == 6'd59) ? 6'd0 : min_q + 6'd1)
                              : ((min_q == 6'd0) ? 6'd59 : min_q - 6'd1);
        F_SEC:   sec_d   = UP ? ((sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1)
                              : ((sec_q == 6'd0) ? 6'd59 : sec_q - 6'd1);
        F_MER:   hour_d  = (hour_q < 5'd12) ? hour_q + 5'd12 : hour_q - 5'd12;
        F_YEAR:  year_d  = UP ? ((year_q >= YMAX) ? 7'd0 : year_q + 7'd1)
                              : ((year_q == 7'd0) ? YMAX : year_q - 7'd1);
        F_MONTH: month_d = UP ? ((month_q >= 4'd12) ? 4'd1 : month_q + 4'd1)
                              : ((month_q <= 4'd1) ? 4'd12 : month_q - 4'd1);
        F_DAY:   day_d   = UP ? ((day_q >= dim_cur) ? 5'd1 : day_q + 5'd1)
                              : ((day_q <= 5'd1) ? dim_cur : day_q - 5'd1);
        default: ;
      endcase
    end else if (tick) begin
      sec_tick_d = 1'b1;
      if (sec_q == 6'd59) begin
        sec_d = 6'd0;
        if (min_q == 6'd59) begin
          min_d = 6'd0;
          if (hour_q == 5'd23) begin
            hour_d     = 5'd0;
            day_roll_d = 1'b1;
            if (day_q >= dim_cur) begin
              day_d = 5'd1;
              if (month_q >= 4'd12) begin
                month_d = 4'd1;
                year_d  = (year_q >= YMAX) ? 7'd0 : year_q + 7'd1;
              end else begin
                month_d = month_q + 4'd1;
              end
            end else begin
              day_d = day_q + 5'd1;
            end
          end else begin
            hour_d = hour_q + 5'd1;
          end
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end

    // A month/year change can leave DAY past the end of the new month.
    dim_new = days_in_month(month_d, year_d);
    if (day_d > dim_new) day_d = dim_new;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      presc_q    <= '0;
      hour_q     <= 5'd0;
      min_q      <= 6'd0;
      sec_q      <= 6'd0;
      year_q     <= 7'd0;
      month_q    <= 4'd1;
      day_q      <= 5'd1;
      sec_tick_q <= 1'b0;
      day_roll_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      hour_q     <= hour_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      year_q     <= year_d;
      month_q    <= month_d;
      day_q      <= day_d;
      sec_tick_q <= sec_tick_d;
      day_roll_q <= day_roll_d;
    end
  end

  assign HOUR     = hour_q;
  assign MIN      = min_q;
  assign SEC      = sec_q;
  assign YEAR     = year_q;
  assign MONTH    = month_q;
  assign DAY      = day_q;
  assign SEC_TICK = sec_tick_q;
  assign DAY_ROLL = day_roll_q;
  assign PM       = (hour_q >= 5'd12);

  always_comb begin
    HOUR_DISP = hour_q;
    if (TIME_FORMAT) begin
      if (hour_q == 5'd0)      HOUR_DISP = 5'd12;
      else if (hour_q > 5'd12) HOUR_DISP = hour_q - 5'd12;
    end
  end

endmodule

// File: tb/tb_rtc_calendar_core.sv
// Directed bench for rtc_calendar_core with a 4-cycle second.
module tb_rtc_calendar_core;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       EN = 1'b0;
  logic       SET_HOLD = 1'b0;
  logic       TIME_FORMAT = 1'b0;
  logic [2:0] FIELD_SEL = 3'd0;
  logic       UP = 1'b0;
  logic       DOWN = 1'b0;
  logic [4:0] HOUR, HOUR_DISP, DAY;
  logic       PM, SEC_TICK, DAY_ROLL;
  logic [5:0] MIN, SEC;
  logic [6:0] YEAR;
  logic [3:0] MONTH;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  rtc_calendar_core #(.TICK_DIV(4), .CNT_W(3), .YEAR_MAX(99)) dut (
    .CLK(CLK), .RESET(RESET), .EN(EN), .SET_HOLD(SET_HOLD), .TIME_FORMAT(TIME_FORMAT),
    .FIELD_SEL(FIELD_SEL), .UP(UP), .DOWN(DOWN),
    .HOUR(HOUR), .HOUR_DISP(HOUR_DISP), .PM(PM), .MIN(MIN), .SEC(SEC),
    .YEAR(YEAR), .MONTH(MONTH), .DAY(DAY), .SEC_TICK(SEC_TICK), .DAY_ROLL(DAY_ROLL)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic edit(input logic [2:0] f, input logic u, input logic d);
    FIELD_SEL = f; UP = u; DOWN = d;
    step();
    FIELD_SEL = 3'd0; UP = 1'b0; DOWN = 1'b0;
  endtask

  task automatic reset_dut();
    RESET = 1'b1; EN = 1'b0; SET_HOLD = 1'b0; TIME_FORMAT = 1'b0;
    step(); step();
    RESET = 1'b0;
    step();
  endtask

  task automatic wait_tick(input string tag);
    int n = 0;
    while (SEC_TICK !== 1'b1 && n < 16) begin
      step();
      n++;
    end
    chk(tag, SEC_TICK, 1);
  endtask

  task automatic chk_date(input string tag, input int y, input int m, input int d,
                          input int h, input int mi, input int s);
    chk({tag, "_year"}, YEAR, y);
    chk({tag, "_month"}, MONTH, m);
    chk({tag, "_day"}, DAY, d);
    chk({tag, "_hour"}, HOUR, h);
    chk({tag, "_min"}, MIN, mi);
    chk({tag, "_sec"}, SEC, s);
  endtask

  // 23:59:59 from 00:00:00 using wrap-around edits
  task automatic set_end_of_day();
    edit(3'd1, 1'b0, 1'b1);
    edit(3'd2, 1'b0, 1'b1);
    edit(3'd3, 1'b0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    step(); step();
    RESET = 1'b0;
    step();
    chk_date("reset", 0, 1, 1, 0, 0, 0);
    chk("reset_pm", PM, 0);
    chk("reset_disp24", HOUR_DISP, 0);
    chk("reset_sec_tick", SEC_TICK, 0);
    chk("reset_day_roll", DAY_ROLL, 0);
    TIME_FORMAT = 1'b1;
    #1;
    chk("reset_disp12", HOUR_DISP, 12);
    TIME_FORMAT = 1'b0;

    // Prescaler: a tick every 4th cycle
    EN = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk($sformatf("presc_tick_c%0d", i), SEC_TICK, (i % 4 == 0) ? 1 : 0);
      chk($sformatf("presc_sec_c%0d", i), SEC, i / 4);
    end
    SET_HOLD = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold_tick", SEC_TICK, 0);
      chk("hold_sec", SEC, 2);
    end
    SET_HOLD = 1'b0;
    EN = 1'b0;

    // Full rollover 99-12-31 23:59:59
    reset_dut();
    edit(3'd5, 1'b0, 1'b1);
    edit(3'd6, 1'b0, 1'b1);
    edit(3'd7, 1'b0, 1'b1);
    set_end_of_day();
    chk_date("preset", 99, 12, 31, 23, 59, 59);
    EN = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("roll_pre_tick", SEC_TICK, 0);
      chk("roll_pre_dayroll", DAY_ROLL, 0);
    end
    step();
    EN = 1'b0;
    chk("roll_tick", SEC_TICK, 1);
    chk("roll_dayroll", DAY_ROLL, 1);
    chk_date("roll", 0, 1, 1, 0, 0, 0);
    step();
    chk("roll_tick_one_cycle", SEC_TICK, 0);
    chk("roll_dayroll_one_cycle", DAY_ROLL, 0);

    // Leap year: 04-02-28 23:59:59 -> 04-02-29
    reset_dut();
    for (int i = 0; i < 4; i++) edit(3'd5, 1'b1, 1'b0);
    edit(3'd6, 1'b1, 1'b0);
    edit(3'd7, 1'b0, 1'b1);
    chk("feb_leap_day_wrap", DAY, 29);
    edit(3'd7, 1'b0, 1'b1);
    set_end_of_day();
    chk_date("leap_preset", 4, 2, 28, 23, 59, 59);
    EN = 1'b1;
    wait_tick("leap_tick");
    EN = 1'b0;
    chk("leap_dayroll", DAY_ROLL, 1);
    chk_date("leap", 4, 2, 29, 0, 0, 0);

    // Non-leap: year 5 clamps 29 -> 28, then tick reaches 03-01
    edit(3'd5, 1'b1, 1'b0);
    chk("year_clamp_day", DAY, 28);
    set_end_of_day();
    EN = 1'b1;
    wait_tick("nonleap_tick");
    EN = 1'b0;
    chk_date("nonleap", 5, 3, 1, 0, 0, 0);

    // 03-31 DOWN on MONTH clamps to 02-28
    edit(3'd7, 1'b0, 1'b1);
    chk("mar_day", DAY, 31);
    edit(3'd6, 1'b0, 1'b1);
    chk("month_clamp_month", MONTH, 2);
    chk("month_clamp_day", DAY, 28);

    // Edit wrap without carry
    edit(3'd2, 1'b0, 1'b1);
    chk("min_wrap", MIN, 59);
    chk("min_wrap_hour", HOUR, 0);
    edit(3'd1, 1'b0, 1'b1);
    chk("hour_down_wrap", HOUR, 23);
    edit(3'd1, 1'b1, 1'b0);
    chk("hour_up_wrap", HOUR, 0);
    chk("hour_up_wrap_day", DAY, 28);
    edit(3'd1, 1'b1, 1'b1);
    chk("updown_hour", HOUR, 0);
    edit(3'd0, 1'b1, 1'b0);
    chk_date("nosel", 5, 2, 28, 0, 59, 0);

    // Edit coincident with tick: edit only
    EN = 1'b1;
    for (int i = 1; i <= 3; i++) step();
    chk("coinc_pre_tick", SEC_TICK, 0);
    edit(3'd2, 1'b1, 1'b0);
    EN = 1'b0;
    chk("coinc_sec_tick", SEC_TICK, 0);
    chk("coinc_sec", SEC, 0);
    chk("coinc_min", MIN, 0);
    chk("coinc_hour", HOUR, 0);

    // 12h display and meridian edits
    for (int i = 0; i < 13; i++) edit(3'd1, 1'b1, 1'b0);
    TIME_FORMAT = 1'b1;
    #1;
    chk("h13_hour", HOUR, 13);
    chk("h13_disp12", HOUR_DISP, 1);
    chk("h13_pm", PM, 1);
    edit(3'd4, 1'b1, 1'b0);
    chk("mer_up_hour", HOUR, 1);
    chk("mer_up_pm", PM, 0);
    chk("mer_up_disp12", HOUR_DISP, 1);
    edit(3'd1, 1'b0, 1'b1);
    chk("h0_disp12", HOUR_DISP, 12);
    edit(3'd4, 1'b0, 1'b1);
    chk("mer_down_hour", HOUR, 12);
    chk("mer_down_pm", PM, 1);
    chk("mer_down_disp12", HOUR_DISP, 12);
    TIME_FORMAT = 1'b0;
    #1;
    chk("fmt_keeps_hour", HOUR, 12);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
